// File: rtl/quicksort_stack.sv
// Iterative in-place Lomuto quicksort over a packed array, driven by an explicit {lo,hi}
// range stack so every sub-range is fully sorted; one element compare per cycle.
module quicksort_stack #(
  parameter int unsigned DATA_W = 4,
  parameter int unsigned N      = 8,
  localparam int unsigned IDX_W = $clog2(N)
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                start,
  input  logic                descending,
  input  logic [IDX_W-1:0]    lo_ind,
  input  logic [IDX_W-1:0]    hi_ind,
  input  logic [N*DATA_W-1:0] array_in,
  output logic                busy,
  output logic                done,
  output logic [N*DATA_W-1:0] sorted_array
);

  // One extra index bit so p-1 at 0 and p+1 at N-1 cannot wrap.
  localparam int unsigned XW     = IDX_W + 1;
  localparam int unsigned STK_D  = N / 2;
  localparam int unsigned SPW    = $clog2(STK_D + 1);
  localparam int unsigned STK_SZ = 1 << SPW;

  typedef enum logic [2:0] {StIdle, StPop, StScan, StFin, StPushL, StPushR} state_e;

  state_e              state_q;
  logic [DATA_W-1:0]   work_q [N];
  logic [XW-1:0]       stk_lo_q [STK_SZ];
  logic [XW-1:0]       stk_hi_q [STK_SZ];
  logic [SPW-1:0]      sp_q;
  logic [XW-1:0]       lo_q, hi_q, i_q, j_q, p_q;
  logic [DATA_W-1:0]   pivot_q;
  logic                desc_q;
  logic                busy_q, done_q;
  logic [N*DATA_W-1:0] sorted_q;

  logic [XW-1:0]     lo_x, hi_x;
  logic [SPW-1:0]    sp_m1;
  logic [XW-1:0]     top_lo, top_hi;
  logic [DATA_W-1:0] w_i, w_j, w_hi;
  logic              cmp;

  always_comb begin
    lo_x   = {1'b0, lo_ind};
    hi_x   = {1'b0, hi_ind};
    sp_m1  = sp_q - 1'b1;
    top_lo = stk_lo_q[sp_m1];
    top_hi = stk_hi_q[sp_m1];
    w_i    = work_q[i_q[IDX_W-1:0]];
    w_j    = work_q[j_q[IDX_W-1:0]];
    w_hi   = work_q[hi_q[IDX_W-1:0]];
    cmp    = desc_q ? (w_j > pivot_q) : (w_j < pivot_q);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      sp_q     <= '0;
      lo_q     <= '0;
      hi_q     <= '0;
      i_q      <= '0;
      j_q      <= '0;
      p_q      <= '0;
      pivot_q  <= '0;
      desc_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      sorted_q <= '0;
      for (int k = 0; k < N; k++) work_q[k] <= '0;
      for (int k = 0; k < STK_SZ; k++) begin
        stk_lo_q[k] <= '0;
        stk_hi_q[k] <= '0;
      end
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            for (int k = 0; k < N; k++) work_q[k] <= array_in[k*DATA_W +: DATA_W];
            desc_q <= descending;
            busy_q <= 1'b1;
            if (lo_x < hi_x && hi_x <= XW'(N - 1)) begin
              stk_lo_q[sp_q] <= lo_x;
              stk_hi_q[sp_q] <= hi_x;
              sp_q           <= sp_q + 1'b1;
            end
            state_q <= StPop;
          end
        end
        StPop: begin
          if (sp_q == '0) begin
            for (int k = 0; k < N; k++) sorted_q[k*DATA_W +: DATA_W] <= work_q[k];
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end else begin
            lo_q    <= top_lo;
            hi_q    <= top_hi;
            pivot_q <= work_q[top_hi[IDX_W-1:0]];
            i_q     <= top_lo;
            j_q     <= top_lo;
            sp_q    <= sp_m1;
            state_q <= StScan;
          end
        end
        StScan: begin
          if (cmp) begin
            work_q[i_q[IDX_W-1:0]] <= w_j;
            work_q[j_q[IDX_W-1:0]] <= w_i;
            i_q <= i_q + 1'b1;
          end
          j_q <= j_q + 1'b1;
          if (j_q == hi_q - XW'(1)) state_q <= StFin;
        end
        StFin: begin
          work_q[i_q[IDX_W-1:0]]  <= w_hi;
          work_q[hi_q[IDX_W-1:0]] <= w_i;
          p_q     <= i_q;
          state_q <= StPushL;
        end
        StPushL: begin
          if (p_q >= lo_q + XW'(2)) begin
            stk_lo_q[sp_q] <= lo_q;
            stk_hi_q[sp_q] <= p_q - XW'(1);
            sp_q           <= sp_q + 1'b1;
          end
          state_q <= StPushR;
        end
        StPushR: begin
          if (hi_q >= p_q + XW'(2)) begin
            stk_lo_q[sp_q] <= p_q + XW'(1);
            stk_hi_q[sp_q] <= hi_q;
            sp_q           <= sp_q + 1'b1;
          end
          state_q <= StPop;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Live ranges are disjoint and at least two wide, so depth is bounded by N/2.
  always_ff @(posedge clock) begin
    if (reset_n) begin
      assert (sp_q <= SPW'(STK_D)) else $error("quicksort_stack: range stack overflow");
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign sorted_array = sorted_q;

endmodule

// File: tb/tb_quicksort_stack.sv
// Directed bench for quicksort_stack (N=8, DATA_W=4) with an expected-result scoreboard.
module tb_quicksort_stack;

  localparam int unsigned DW = 4;
  localparam int unsigned NN = 8;
  localparam int unsigned W  = DW * NN;

  logic         clock = 1'b0;
  logic         reset_n;
  logic         start;
  logic         descending;
  logic [2:0]   lo_ind, hi_ind;
  logic [W-1:0] array_in;
  logic         busy, done;
  logic [W-1:0] sorted_array;

  int n_tests = 0;
  int n_fail  = 0;
  int done_pulses = 0;
  int sp_max = 0;
  logic [W-1:0] sb[$];

  quicksort_stack #(.DATA_W(DW), .N(NN)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .start        (start),
    .descending   (descending),
    .lo_ind       (lo_ind),
    .hi_ind       (hi_ind),
    .array_in     (array_in),
    .busy         (busy),
    .done         (done),
    .sorted_array (sorted_array)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (done === 1'b1) done_pulses++;
    if (reset_n === 1'b1 && int'(dut.sp_q) > sp_max) sp_max = int'(dut.sp_q);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Insertion sort of the selected range; invalid/empty ranges leave data untouched.
  function automatic logic [W-1:0] ref_sort(input logic [W-1:0] d, input logic desc,
                                            input int lo, input int hi);
    logic [DW-1:0] a [NN];
    logic [DW-1:0] key;
    int            y;
    logic [W-1:0]  r;
    for (int k = 0; k < NN; k++) a[k] = d[k*DW +: DW];
    if (lo < hi && hi <= NN - 1) begin
      for (int x = lo + 1; x <= hi; x++) begin
        key = a[x];
        y   = x - 1;
        while (y >= lo && (desc ? (a[y] < key) : (a[y] > key))) begin
          a[y+1] = a[y];
          y--;
        end
        a[y+1] = key;
      end
    end
    for (int k = 0; k < NN; k++) r[k*DW +: DW] = a[k];
    return r;
  endfunction

  task automatic start_sort(input logic [W-1:0] data, input logic desc, input int lo,
                            input int hi);
    @(negedge clock);
    array_in   = data;
    descending = desc;
    lo_ind     = 3'(lo);
    hi_ind     = 3'(hi);
    start      = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
  endtask

  // Returns edges waited after the sampling edge; also checks the pulse is one cycle wide.
  task automatic wait_done(input string tag, output int cyc);
    logic [W-1:0] exp;
    cyc = 0;
    while (done !== 1'b1 && cyc < 400) begin
      @(posedge clock);
      #1;
      cyc++;
    end
    check({tag, "_done_seen"}, W'(done), W'(1));
    exp = (sb.size() > 0) ? sb.pop_front() : 'x;
    check({tag, "_result"}, sorted_array, exp);
    @(posedge clock);
    #1;
    check({tag, "_done_low"}, W'(done), W'(0));
    check({tag, "_busy_low"}, W'(busy), W'(0));
  endtask

  initial begin
    int cyc;
    int p0;
    logic [W-1:0] b;
    reset_n    = 1'b0;
    start      = 1'b0;
    descending = 1'b0;
    lo_ind     = '0;
    hi_ind     = '0;
    array_in   = '0;
    repeat (2) @(posedge clock);
    #1;
    check("reset_busy", W'(busy), W'(0));
    check("reset_done", W'(done), W'(0));
    check("reset_sorted", sorted_array, '0);
    @(negedge clock) reset_n = 1'b1;

    // T1: elements {7,3,5,1,6,2,4,0} ascending over the full range.
    p0 = done_pulses;
    sb.push_back(32'h7654_3210);
    start_sort(32'h0426_1537, 1'b0, 0, 7);
    check("t1_busy_high", W'(busy), W'(1));
    wait_done("t1", cyc);
    repeat (3) @(posedge clock);
    #1 check("t1_one_done", W'(done_pulses - p0), W'(1));

    // T2: same data descending.
    sb.push_back(32'h0123_4567);
    start_sort(32'h0426_1537, 1'b1, 0, 7);
    wait_done("t2", cyc);

    // T3: all-equal keys, then already sorted input.
    sp_max = 0;
    sb.push_back(32'h5555_5555);
    start_sort(32'h5555_5555, 1'b0, 0, 7);
    wait_done("t3_equal", cyc);
    sb.push_back(32'h7654_3210);
    start_sort(32'h7654_3210, 1'b0, 0, 7);
    wait_done("t3_sorted", cyc);
    check("t3_sp_bound", W'(sp_max <= 4), W'(1));

    // T4: sub-range [2,5] of {9,8,7,6,5,4,3,2}, then degenerate range lo=hi=3.
    sb.push_back(32'h2376_5489);
    start_sort(32'h2345_6789, 1'b0, 2, 5);
    wait_done("t4_sub", cyc);
    sb.push_back(32'h2345_6789);
    start_sort(32'h2345_6789, 1'b0, 3, 3);
    wait_done("t4_empty", cyc);
    check("t4_empty_latency", W'(cyc), W'(1));

    // T5: a second start while busy must be ignored.
    b  = 32'h3c1a_9e52;
    p0 = done_pulses;
    sb.push_back(32'h7654_3210);
    start_sort(32'h0426_1537, 1'b0, 0, 7);
    repeat (4) @(posedge clock);
    start_sort(b, 1'b1, 1, 6);
    wait_done("t5_first", cyc);
    check("t5_single_done", W'(done_pulses - p0), W'(1));
    sb.push_back(ref_sort(b, 1'b0, 0, 7));
    start_sort(b, 1'b0, 0, 7);
    wait_done("t5_second", cyc);

    // T6: asynchronous reset in the middle of a scan.
    sb.push_back(ref_sort(32'hf0e1_d2c3, 1'b0, 0, 7));
    start_sort(32'hf0e1_d2c3, 1'b0, 0, 7);
    repeat (3) @(posedge clock);
    #2 reset_n = 1'b0;
    #1;
    check("t6_rst_busy", W'(busy), W'(0));
    check("t6_rst_done", W'(done), W'(0));
    check("t6_rst_sorted", sorted_array, '0);
    sb.delete();
    @(negedge clock) reset_n = 1'b1;
    b = 32'h9a2b_7c18;
    sb.push_back(ref_sort(b, 1'b1, 0, 7));
    start_sort(b, 1'b1, 0, 7);
    wait_done("t6_after", cyc);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
